// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants for the output-stationary convolution core
package core_pkg;

    // Datapath geometry defaults
    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int ROW     = 8;
    localparam int COL     = 8;

    // Instruction word layout
    localparam int INST_W  = 40;
    localparam int I_LOAD  = 0;
    localparam int I_EXEC  = 1;
    localparam int I_MODE  = 2;
    localparam int I_L0_WR = 3;
    localparam int I_L0_RD = 4;
    localparam int I_IF_RD = 5;
    localparam int I_IF_WR = 6;
    localparam int I_OF_RD = 7;
    localparam int I_A0    = 8;
    localparam int I_WEN0  = 16;
    localparam int I_CEN0  = 17;
    localparam int I_A1    = 18;
    localparam int I_CEN1  = 26;
    localparam int I_RSVD  = 27;

    // xmem geometry
    localparam int XMEM_WORDS = 256;
    localparam int XMEM_AW    = 8;

    // FIFO depths and pointer widths
    localparam int L0_DEPTH = 64;
    localparam int L0_AW    = 6;
    localparam int OF_DEPTH = 16;
    localparam int OF_AW    = 4;

    // Drain sequencer states
    typedef enum logic [1:0] {
        DR_IDLE  = 2'd0,
        DR_WAIT  = 2'd1,
        DR_SHIFT = 2'd2
    } drain_state_e;

endpackage

// File: rtl/os_pe.sv
// rtl/os_pe.sv - one processing element: tagged a/w forwarding, signed MAC, psum drain shift
module os_pe
    import core_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic               shift,
    input  logic [bw-1:0]      a_in,
    input  logic               a_vld_in,
    input  logic [bw-1:0]      w_in,
    input  logic               w_vld_in,
    input  logic [psum_bw-1:0] psum_in,
    output logic [bw-1:0]      a_out,
    output logic               a_vld_out,
    output logic [bw-1:0]      w_out,
    output logic               w_vld_out,
    output logic [psum_bw-1:0] psum_out
);
    localparam int PW = 2 * bw + 1;

    logic [PW-1:0]        a_ext, w_ext;
    logic signed [PW-1:0] prod;
    logic [psum_bw-1:0]   prod_ext;
    logic [bw-1:0]        a_q, a_d, w_q, w_d;
    logic                 a_vld_q, a_vld_d, w_vld_q, w_vld_d;
    logic [psum_bw-1:0]   psum_q, psum_d;

    // Unsigned activation times signed weight; drain shift takes priority over the MAC
    always_comb begin
        a_ext    = {{(bw + 1){1'b0}}, a_in};
        w_ext    = {{(bw + 1){w_in[bw-1]}}, w_in};
        prod     = $signed(a_ext) * $signed(w_ext);
        prod_ext = {{(psum_bw - PW){prod[PW-1]}}, prod};
        a_d      = a_in;
        a_vld_d  = a_vld_in;
        w_d      = w_in;
        w_vld_d  = w_vld_in;
        psum_d   = psum_q;
        if (shift) begin
            psum_d = psum_in;
        end else if (mode && a_vld_in && w_vld_in) begin
            psum_d = psum_q + prod_ext;
        end
    end

    // PE state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            a_vld_q <= 1'b0;
            w_q     <= '0;
            w_vld_q <= 1'b0;
            psum_q  <= '0;
        end else begin
            a_q     <= a_d;
            a_vld_q <= a_vld_d;
            w_q     <= w_d;
            w_vld_q <= w_vld_d;
            psum_q  <= psum_d;
        end
    end

    assign a_out     = a_q;
    assign a_vld_out = a_vld_q;
    assign w_out     = w_q;
    assign w_vld_out = w_vld_q;
    assign psum_out  = psum_q;

endmodule

// File: rtl/os_core.sv
// rtl/os_core.sv - output-stationary conv core top (xmem, L0/IFIFO, skew, PE array, drain, OFIFO); CORE_RELU_EN enables ReLU on sfp_out
module os_core
    import core_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW,
    parameter int row     = ROW,
    parameter int col     = COL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INST_W-1:0]      inst,
    input  logic [bw*row-1:0]      D_xmem,
    output logic [col*psum_bw-1:0] sfp_out,
    output logic                   ofifo_valid,
    output logic                   l0_ready,
    output logic                   ififo_ready
);
    localparam int XW  = bw * row;
    localparam int OW  = col * psum_bw;
    localparam int DCW = $clog2(row);

    // Instruction decode
    logic cen0, wen0, cen1, l0_wr, l0_rd, if_wr, if_rd, of_rd, mode, load;
    logic [XMEM_AW-1:0] a0, a1;
    logic unused_inst;
    assign cen0  = inst[I_CEN0];
    assign wen0  = inst[I_WEN0];
    assign cen1  = inst[I_CEN1];
    assign a0    = inst[I_A0 +: XMEM_AW];
    assign a1    = inst[I_A1 +: XMEM_AW];
    assign l0_wr = inst[I_L0_WR];
    assign l0_rd = inst[I_L0_RD];
    assign if_wr = inst[I_IF_WR];
    assign if_rd = inst[I_IF_RD];
    assign of_rd = inst[I_OF_RD];
    assign mode  = inst[I_MODE];
    assign load  = inst[I_LOAD];
    assign unused_inst = ^{inst[INST_W-1:I_RSVD], inst[I_EXEC]};

    logic [XW-1:0]       xmem_mem [XMEM_WORDS];
    logic [XW-1:0]       l0_mem [L0_DEPTH];
    logic [XW-1:0]       if_mem [L0_DEPTH];
    logic [OW-1:0]       of_mem [OF_DEPTH];
    logic [XW-1:0]       q0_q, q0_d, q1_q, q1_d;
    logic [L0_AW-1:0]    l0_wp_q, l0_wp_d, l0_rp_q, l0_rp_d, if_wp_q, if_wp_d, if_rp_q, if_rp_d;
    logic [L0_AW:0]      l0_cnt_q, l0_cnt_d, if_cnt_q, if_cnt_d;
    logic [OF_AW-1:0]    of_wp_q, of_wp_d, of_rp_q, of_rp_d;
    logic [OF_AW:0]      of_cnt_q, of_cnt_d;
    logic                l0_push, l0_pop, if_push, if_pop, of_push, of_pop, in_flight;
    logic [XW-1:0]       act_sk_q [row], act_sk_d [row], wgt_sk_q [col], wgt_sk_d [col];
    logic [row-1:0]      act_sv_q, act_sv_d;
    logic [col-1:0]      wgt_sv_q, wgt_sv_d;
    logic [OW-1:0]       drain_word, of_head;
    drain_state_e        dr_state_q;
    logic [DCW-1:0]      dr_cnt_q;
    logic                shift_q;

    // PE interconnect: activations flow east, weights and psums flow south
    logic [bw-1:0]       a_h  [row][col+1];
    logic                av_h [row][col+1];
    logic [bw-1:0]       w_v  [row+1][col];
    logic                wv_v [row+1][col];
    logic [psum_bw-1:0]  p_v  [row+1][col];

    assign l0_ready    = ~l0_cnt_q[L0_AW];
    assign ififo_ready = ~if_cnt_q[L0_AW];
    assign ofifo_valid = (of_cnt_q != '0);

    // Next-state for xmem read ports, FIFO pointers/counts and skew chains
    always_comb begin
        q0_d = q0_q;
        q1_d = q1_q;
        if (!cen0 && wen0) q0_d = xmem_mem[a0];
        if (!cen1)         q1_d = xmem_mem[a1];
        l0_push  = l0_wr & l0_ready;
        l0_pop   = l0_rd & (l0_cnt_q != '0);
        if_push  = if_wr & ififo_ready;
        if_pop   = if_rd & (if_cnt_q != '0);
        of_push  = shift_q & ~of_cnt_q[OF_AW];
        of_pop   = of_rd & ofifo_valid;
        l0_wp_d  = l0_wp_q + L0_AW'(l0_push);
        l0_rp_d  = l0_rp_q + L0_AW'(l0_pop);
        l0_cnt_d = l0_cnt_q + (L0_AW + 1)'(l0_push) - (L0_AW + 1)'(l0_pop);
        if_wp_d  = if_wp_q + L0_AW'(if_push);
        if_rp_d  = if_rp_q + L0_AW'(if_pop);
        if_cnt_d = if_cnt_q + (L0_AW + 1)'(if_push) - (L0_AW + 1)'(if_pop);
        of_wp_d  = of_wp_q + OF_AW'(of_push);
        of_rp_d  = of_rp_q + OF_AW'(of_pop);
        of_cnt_d = of_cnt_q + (OF_AW + 1)'(of_push) - (OF_AW + 1)'(of_pop);
        act_sk_d[0] = l0_pop ? l0_mem[l0_rp_q] : '0;
        act_sv_d    = {act_sv_q[row-2:0], l0_pop};
        for (int k = 1; k < row; k++) act_sk_d[k] = act_sk_q[k-1];
        wgt_sk_d[0] = if_pop ? if_mem[if_rp_q] : '0;
        wgt_sv_d    = {wgt_sv_q[col-2:0], if_pop};
        for (int k = 1; k < col; k++) wgt_sk_d[k] = wgt_sk_q[k-1];
    end

    // Datapath control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            q0_q <= '0;  q1_q <= '0;
            l0_wp_q <= '0; l0_rp_q <= '0; l0_cnt_q <= '0;
            if_wp_q <= '0; if_rp_q <= '0; if_cnt_q <= '0;
            of_wp_q <= '0; of_rp_q <= '0; of_cnt_q <= '0;
            act_sv_q <= '0; wgt_sv_q <= '0;
            for (int k = 0; k < row; k++) act_sk_q[k] <= '0;
            for (int k = 0; k < col; k++) wgt_sk_q[k] <= '0;
        end else begin
            q0_q <= q0_d;  q1_q <= q1_d;
            l0_wp_q <= l0_wp_d; l0_rp_q <= l0_rp_d; l0_cnt_q <= l0_cnt_d;
            if_wp_q <= if_wp_d; if_rp_q <= if_rp_d; if_cnt_q <= if_cnt_d;
            of_wp_q <= of_wp_d; of_rp_q <= of_rp_d; of_cnt_q <= of_cnt_d;
            act_sv_q <= act_sv_d; wgt_sv_q <= wgt_sv_d;
            for (int k = 0; k < row; k++) act_sk_q[k] <= act_sk_d[k];
            for (int k = 0; k < col; k++) wgt_sk_q[k] <= wgt_sk_d[k];
        end
    end

    // Storage arrays carry no reset; pointers and counts define their contents
    always_ff @(posedge clk) begin
        if (!cen0 && !wen0) xmem_mem[a0]      <= D_xmem;
        if (l0_push)        l0_mem[l0_wp_q]   <= q0_q;
        if (if_push)        if_mem[if_wp_q]   <= q1_q;
        if (of_push)        of_mem[of_wp_q]   <= drain_word;
    end

    // PE array with skewed edge inputs; lane r/c comes from skew stage r/c
    for (genvar r = 0; r < row; r++) begin : g_row
        assign a_h[r][0]  = act_sk_q[r][bw*r +: bw];
        assign av_h[r][0] = act_sv_q[r];
        for (genvar c = 0; c < col; c++) begin : g_col
            os_pe #(.bw(bw), .psum_bw(psum_bw)) u_pe (
                .clk(clk), .reset(reset), .mode(mode), .shift(shift_q),
                .a_in(a_h[r][c]), .a_vld_in(av_h[r][c]),
                .w_in(w_v[r][c]), .w_vld_in(wv_v[r][c]), .psum_in(p_v[r][c]),
                .a_out(a_h[r][c+1]), .a_vld_out(av_h[r][c+1]),
                .w_out(w_v[r+1][c]), .w_vld_out(wv_v[r+1][c]), .psum_out(p_v[r+1][c])
            );
        end
    end
    for (genvar c = 0; c < col; c++) begin : g_top
        assign w_v[0][c]  = wgt_sk_q[c][bw*c +: bw];
        assign wv_v[0][c] = wgt_sv_q[c];
        assign p_v[0][c]  = '0;
    end

    // Tag flush detection, bottom-row drain word and OFIFO head formatting
    always_comb begin
        in_flight  = (|act_sv_q) | (|wgt_sv_q);
        drain_word = '0;
        for (int r = 0; r < row; r++)
            for (int c = 0; c < col; c++)
                in_flight = in_flight | av_h[r][c+1] | wv_v[r+1][c];
        for (int c = 0; c < col; c++) drain_word[c*psum_bw +: psum_bw] = p_v[row][c];
        of_head = ofifo_valid ? of_mem[of_rp_q] : '0;
        sfp_out = of_head;
`ifdef CORE_RELU_EN
        for (int c = 0; c < col; c++)
            if (of_head[c*psum_bw + psum_bw - 1]) sfp_out[c*psum_bw +: psum_bw] = '0;
`endif
    end

    // Drain sequencer: arm on load+mode, wait for tags to flush, then shift row times
    always_ff @(posedge clk) begin
        if (reset) begin
            dr_state_q <= DR_IDLE;
            dr_cnt_q   <= '0;
            shift_q    <= 1'b0;
        end else begin
            case (dr_state_q)
                DR_IDLE: if (load && mode) dr_state_q <= DR_WAIT;
                DR_WAIT: if (!in_flight) begin
                    dr_state_q <= DR_SHIFT;
                    dr_cnt_q   <= '0;
                    shift_q    <= 1'b1;
                end
                DR_SHIFT: begin
                    dr_cnt_q <= dr_cnt_q + DCW'(1);
                    if (dr_cnt_q == DCW'(row - 1)) begin
                        dr_state_q <= DR_IDLE;
                        shift_q    <= 1'b0;
                    end
                end
                default: dr_state_q <= DR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_os_core.sv
// tb/tb_os_core.sv - directed self-checking bench for os_core
module tb_os_core;

    logic         clk = 1'b0;
    logic         reset;
    logic [39:0]  inst;
    logic [31:0]  D_xmem;
    logic [127:0] sfp_out;
    logic         ofifo_valid, l0_ready, ififo_ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] act_v [27];
    logic [31:0] wgt_v [27];
    logic [15:0] exp_ps [8][8];

    localparam logic [39:0] IDLE_I = (40'd1 << 26) | (40'd1 << 17) | (40'd1 << 16);
    localparam logic [39:0] MODE_B = 40'd1 << 2;
    localparam logic [39:0] OFRD_B = 40'd1 << 7;

    os_core dut (
        .clk(clk), .reset(reset), .inst(inst), .D_xmem(D_xmem),
        .sfp_out(sfp_out), .ofifo_valid(ofifo_valid),
        .l0_ready(l0_ready), .ififo_ready(ififo_ready)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [39:0] v);
        inst = v;
        @(posedge clk);
        #1;
    endtask

    task automatic stream_and_drain();
        logic [39:0] v;
        int n;
        for (int t = 0; t < 27; t++) begin
            v = IDLE_I; v[17] = 1'b0; v[16] = 1'b0; v[15:8] = 8'(t);
            D_xmem = act_v[t];
            step(v);
            v[15:8] = 8'(128 + t);
            D_xmem = wgt_v[t];
            step(v);
        end
        for (int k = 0; k < 28; k++) begin
            v = IDLE_I | MODE_B;
            if (k < 27) begin
                v[17] = 1'b0; v[16] = 1'b1; v[15:8] = 8'(k);
                v[26] = 1'b0; v[25:18] = 8'(128 + k);
            end
            if (k > 0) begin v[3] = 1'b1; v[6] = 1'b1; end
            step(v);
        end
        for (int k = 0; k < 27; k++) begin
            v = IDLE_I | MODE_B; v[4] = 1'b1; v[5] = 1'b1;
            step(v);
        end
        step(IDLE_I | MODE_B | 40'd1);
        n = 0;
        while (!ofifo_valid && n < 40) begin
            step(IDLE_I | MODE_B);
            n++;
        end
        checks++;
        if (ofifo_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_timeout ofifo_valid=%b required=1", ofifo_valid);
        end
        repeat (12) step(IDLE_I | MODE_B);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        D_xmem = '0;
        repeat (10) step(IDLE_I);
        checks++; if (ofifo_valid !== 1'b0) begin errors++; $display("FAIL reset_ofifo_valid got=%b exp=0", ofifo_valid); end
        checks++; if (l0_ready !== 1'b1) begin errors++; $display("FAIL reset_l0_ready got=%b exp=1", l0_ready); end
        checks++; if (ififo_ready !== 1'b1) begin errors++; $display("FAIL reset_ififo_ready got=%b exp=1", ififo_ready); end
        checks++; if (sfp_out !== 128'd0) begin errors++; $display("FAIL reset_sfp_out got=%h exp=0", sfp_out); end
        reset = 1'b0;
        step(IDLE_I);
    endtask

    task automatic test_xmem();
        logic [39:0] v;
        v = IDLE_I; v[17] = 1'b0; v[16] = 1'b0; v[15:8] = 8'd5;
        D_xmem = 32'h1234_5678;
        step(v);
        D_xmem = '0;
        v = IDLE_I; v[17] = 1'b0; v[16] = 1'b1; v[15:8] = 8'd5; v[26] = 1'b0; v[25:18] = 8'd5;
        step(v);
        checks++; if (dut.q0_q !== 32'h1234_5678) begin errors++; $display("FAIL xmem_q0 got=%h exp=12345678", dut.q0_q); end
        checks++; if (dut.q1_q !== 32'h1234_5678) begin errors++; $display("FAIL xmem_q1 got=%h exp=12345678", dut.q1_q); end
        step(IDLE_I);
    endtask

    task automatic test_ones();
        for (int t = 0; t < 27; t++) begin act_v[t] = 32'h1111_1111; wgt_v[t] = 32'h1111_1111; end
        stream_and_drain();
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (sfp_out[16*c +: 16] !== 16'd27) begin
                    errors++;
                    $display("FAIL ones_w%0d_c%0d got=%h exp=001b", i, c, sfp_out[16*c +: 16]);
                end
            end
            step(IDLE_I | OFRD_B);
        end
        step(IDLE_I | OFRD_B);
        checks++; if (ofifo_valid !== 1'b0) begin errors++; $display("FAIL ones_empty_pop ofifo_valid=%b exp=0", ofifo_valid); end
        checks++; if (sfp_out !== 128'd0) begin errors++; $display("FAIL ones_empty_sfp got=%h exp=0", sfp_out); end
    endtask

    task automatic test_negative();
        logic [15:0] exp_v;
`ifdef CORE_RELU_EN
        exp_v = 16'h0000;
`else
        exp_v = 16'hF358;
`endif
        for (int t = 0; t < 27; t++) begin act_v[t] = 32'hFFFF_FFFF; wgt_v[t] = 32'h8888_8888; end
        stream_and_drain();
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (sfp_out[16*c +: 16] !== exp_v) begin
                    errors++;
                    $display("FAIL neg_w%0d_c%0d got=%h exp=%h", i, c, sfp_out[16*c +: 16], exp_v);
                end
            end
            step(IDLE_I | OFRD_B);
        end
        checks++; if (ofifo_valid !== 1'b0) begin errors++; $display("FAIL neg_drained ofifo_valid=%b exp=0", ofifo_valid); end
    endtask

    task automatic test_random();
        int s;
        logic [3:0] av;
        logic signed [3:0] wv;
        logic [15:0] got, want;
        for (int t = 0; t < 27; t++) begin act_v[t] = $urandom; wgt_v[t] = $urandom; end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                s = 0;
                for (int t = 0; t < 27; t++) begin
                    av = act_v[t][4*r +: 4];
                    wv = wgt_v[t][4*c +: 4];
                    s += int'(av) * int'(wv);
                end
                exp_ps[r][c] = s[15:0];
`ifdef CORE_RELU_EN
                if (exp_ps[r][c][15]) exp_ps[r][c] = 16'h0000;
`endif
            end
        end
        stream_and_drain();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ofifo_valid !== 1'b1) begin errors++; $display("FAIL rand_valid_w%0d got=%b exp=1", i, ofifo_valid); end
            for (int c = 0; c < 8; c++) begin
                got  = sfp_out[16*c +: 16];
                want = exp_ps[7-i][c];
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL rand_w%0d_c%0d got=%h exp=%h", i, c, got, want);
                end
            end
            step(IDLE_I | OFRD_B);
        end
        checks++; if (ofifo_valid !== 1'b0) begin errors++; $display("FAIL rand_valid_fall got=%b exp=0", ofifo_valid); end
    endtask

    task automatic test_l0_full();
        logic [39:0] v;
        v = IDLE_I; v[17] = 1'b0; v[16] = 1'b1; v[15:8] = 8'd0;
        step(v);
        v = IDLE_I; v[3] = 1'b1;
        for (int k = 0; k < 63; k++) step(v);
        checks++; if (l0_ready !== 1'b1) begin errors++; $display("FAIL l0_ready_63 got=%b exp=1", l0_ready); end
        step(v);
        checks++; if (l0_ready !== 1'b0) begin errors++; $display("FAIL l0_ready_64 got=%b exp=0", l0_ready); end
        step(v);
        checks++; if (dut.l0_cnt_q !== 7'd64) begin errors++; $display("FAIL l0_drop_65 count=%0d exp=64", dut.l0_cnt_q); end
        checks++; if (ififo_ready !== 1'b1) begin errors++; $display("FAIL ififo_ready_idle got=%b exp=1", ififo_ready); end
        v = IDLE_I; v[4] = 1'b1;
        step(v);
        checks++; if (l0_ready !== 1'b1) begin errors++; $display("FAIL l0_ready_after_pop got=%b exp=1", l0_ready); end
        checks++; if (dut.l0_cnt_q !== 7'd63) begin errors++; $display("FAIL l0_count_after_pop count=%0d exp=63", dut.l0_cnt_q); end
        for (int k = 0; k < 63; k++) step(v);
        repeat (20) step(IDLE_I);
    endtask

    initial begin
        inst   = IDLE_I;
        D_xmem = '0;
        reset  = 1'b1;
        test_reset();
        test_xmem();
        test_ones();
        test_negative();
        test_random();
        test_l0_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
